// File: rtl/metaball_animator.sv
`default_nettype none
// ==========================================================================
// metaball_animator : per-frame ball position update with margin bounce
// Revision          : 1.0
// ==========================================================================
module metaball_animator #(
  parameter int NUM_BALLS        = 3,
  parameter int SCREEN_WIDTH     = 640,
  parameter int SCREEN_HEIGHT    = 480,
  parameter int MARGIN           = 32,
  parameter bit VSYNC_ACTIVE_LOW = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   vsync,
  input  logic                   pause,
  input  logic [1:0]             speed,
  output logic [NUM_BALLS*10-1:0] ball_x,
  output logic [NUM_BALLS*10-1:0] ball_y,
  output logic                   busy,
  output logic [7:0]             frame_count,
  output logic                   overrun
);

  localparam logic [10:0] c_lo      = 11'(MARGIN);
  localparam logic [10:0] c_hi_x    = 11'(SCREEN_WIDTH - 1 - MARGIN);
  localparam logic [10:0] c_hi_y    = 11'(SCREEN_HEIGHT - 1 - MARGIN);
  localparam logic [2:0]  c_last    = 3'(NUM_BALLS - 1);
  localparam logic        c_vs_idle = VSYNC_ACTIVE_LOW ? 1'b1 : 1'b0;
  localparam logic [9:0]  c_init_y  = 10'(SCREEN_HEIGHT / 2);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UPD_X  = 2'd1,
    UPD_Y  = 2'd2,
    COMMIT = 2'd3
  } state_t;

  state_t r_state, w_next_state;

  logic                 r_vs_q;
  logic [2:0]           r_idx;
  logic [1:0]           r_shift;
  logic [7:0]           r_frame_count;
  logic                 r_overrun;
  logic [9:0]           r_wx [NUM_BALLS];
  logic [9:0]           r_wy [NUM_BALLS];
  logic [9:0]           r_bx [NUM_BALLS];
  logic [9:0]           r_by [NUM_BALLS];
  logic [NUM_BALLS-1:0] r_dx;
  logic [NUM_BALLS-1:0] r_dy;

  logic        w_frame_start;
  logic [1:0]  w_speed_sat;
  logic [9:0]  w_pos;
  logic        w_dir;
  logic [10:0] w_base;
  logic [10:0] w_step;
  logic [10:0] w_hi;
  logic [10:0] w_sum;
  logic [9:0]  w_new_pos;
  logic        w_flip;

  function automatic logic [9:0] f_init_x(input int i);
    return 10'((i + 1) * SCREEN_WIDTH / (NUM_BALLS + 1));
  endfunction

  assign w_frame_start = (vsync != c_vs_idle) && (r_vs_q == c_vs_idle);
  assign w_speed_sat   = (speed == 2'd3) ? 2'd2 : speed;

  // Select the coordinate and direction of the ball/axis being processed.
  always_comb begin
    w_pos = '0;
    w_dir = 1'b0;
    for (int i = 0; i < NUM_BALLS; i++) begin
      if (r_idx == 3'(i)) begin
        w_pos = (r_state == UPD_X) ? r_wx[i] : r_wy[i];
        w_dir = (r_state == UPD_X) ? r_dx[i] : r_dy[i];
      end
    end
  end

  assign w_base = (r_state == UPD_X) ? ({8'd0, r_idx} + 11'd1) : ({8'd0, r_idx} + 11'd2);
  assign w_step = w_base << r_shift;
  assign w_hi   = (r_state == UPD_X) ? c_hi_x : c_hi_y;
  assign w_sum  = {1'b0, w_pos} + w_step;

  always_comb begin
    w_new_pos = w_pos;
    w_flip    = 1'b0;
    if (w_dir) begin
      if (w_sum > w_hi) begin
        w_new_pos = w_hi[9:0];
        w_flip    = 1'b1;
      end else begin
        w_new_pos = w_sum[9:0];
      end
    end else begin
      if ({1'b0, w_pos} < c_lo + w_step) begin
        w_new_pos = c_lo[9:0];
        w_flip    = 1'b1;
      end else begin
        w_new_pos = w_pos - w_step[9:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_frame_start && !pause) w_next_state = UPD_X;
      UPD_X:   w_next_state = UPD_Y;
      UPD_Y:   w_next_state = (r_idx == c_last) ? COMMIT : UPD_X;
      COMMIT:  w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vs_q        <= c_vs_idle;
      r_idx         <= '0;
      r_shift       <= '0;
      r_frame_count <= '0;
      r_overrun     <= 1'b0;
      for (int i = 0; i < NUM_BALLS; i++) begin
        r_wx[i] <= f_init_x(i);
        r_wy[i] <= c_init_y;
        r_bx[i] <= f_init_x(i);
        r_by[i] <= c_init_y;
        r_dx[i] <= 1'b1;
        r_dy[i] <= ((i % 2) == 0);
      end
    end else begin
      r_vs_q <= vsync;
      if (w_frame_start) begin
        r_frame_count <= r_frame_count + 8'd1;
        if (r_state != IDLE) begin
          r_overrun <= 1'b1;
        end else if (!pause) begin
          r_idx   <= '0;
          r_shift <= w_speed_sat;
        end
      end
      if (r_state == UPD_X || r_state == UPD_Y) begin
        for (int i = 0; i < NUM_BALLS; i++) begin
          if (r_idx == 3'(i)) begin
            if (r_state == UPD_X) begin
              r_wx[i] <= w_new_pos;
              r_dx[i] <= r_dx[i] ^ w_flip;
            end else begin
              r_wy[i] <= w_new_pos;
              r_dy[i] <= r_dy[i] ^ w_flip;
            end
          end
        end
        if (r_state == UPD_Y) r_idx <= r_idx + 3'd1;
      end
      // Positions become visible only here, all balls in the same cycle.
      if (r_state == COMMIT) begin
        r_bx <= r_wx;
        r_by <= r_wy;
      end
    end
  end

  for (genvar g = 0; g < NUM_BALLS; g++) begin : g_pack
    assign ball_x[10*g +: 10] = r_bx[g];
    assign ball_y[10*g +: 10] = r_by[g];
  end

  assign busy        = (r_state != IDLE);
  assign frame_count = r_frame_count;
  assign overrun     = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_metaball_animator.sv
`default_nettype none
// ==========================================================================
// tb_metaball_animator : directed + random bench with a frame-level model
// Revision             : 1.0
// ==========================================================================
module tb_metaball_animator;

  localparam int N  = 3;
  localparam int W  = 640;
  localparam int H  = 480;
  localparam int MG = 32;
  localparam int HI_X = W - 1 - MG;
  localparam int HI_Y = H - 1 - MG;

  logic            clk;
  logic            rst_n;
  logic            vsync;
  logic            pause;
  logic [1:0]      speed;
  logic [N*10-1:0] ball_x;
  logic [N*10-1:0] ball_y;
  logic            busy;
  logic [7:0]      frame_count;
  logic            overrun;

  metaball_animator #(
    .NUM_BALLS(N), .SCREEN_WIDTH(W), .SCREEN_HEIGHT(H),
    .MARGIN(MG), .VSYNC_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .vsync(vsync), .pause(pause), .speed(speed),
    .ball_x(ball_x), .ball_y(ball_y), .busy(busy),
    .frame_count(frame_count), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: a whole frame's motion is computed at the frame
  // start, and becomes visible 2*N+1 edges later.
  int mpx[N], mpy[N], mbx[N], mby[N];
  bit mdx[N], mdy[N];
  int m_cnt, m_fc;
  bit m_ov, m_prev, m_valid;

  function automatic int step_axis(input int p, input int st, input int hi, inout bit dir);
    if (dir) begin
      if (p + st > hi) begin dir = 1'b0; return hi; end
      return p + st;
    end
    if (p < MG + st) begin dir = 1'b1; return MG; end
    return p - st;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mpx[i] = (i + 1) * W / (N + 1);
      mpy[i] = H / 2;
      mbx[i] = mpx[i];
      mby[i] = mpy[i];
      mdx[i] = 1'b1;
      mdy[i] = (i % 2 == 0);
    end
    m_cnt = 0; m_fc = 0; m_ov = 1'b0; m_prev = 1'b0;
  endtask

  initial begin
    m_valid = 1'b0;
    model_reset();
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        model_reset();
        m_valid = 1'b1;
      end else begin
        bit fs, was_busy;
        int sh;
        fs       = (vsync == 1'b0) && !m_prev;
        m_prev   = (vsync == 1'b0);
        was_busy = (m_cnt != 0);
        if (was_busy) begin
          m_cnt--;
          if (m_cnt == 0) begin
            mbx = mpx;
            mby = mpy;
          end
        end
        if (fs) begin
          m_fc = (m_fc + 1) % 256;
          if (was_busy) m_ov = 1'b1;
          else if (!pause) begin
            sh = (speed > 2) ? 2 : int'(speed);
            for (int i = 0; i < N; i++) begin
              mpx[i] = step_axis(mpx[i], (i + 1) << sh, HI_X, mdx[i]);
              mpy[i] = step_axis(mpy[i], (i + 2) << sh, HI_Y, mdy[i]);
            end
            m_cnt = 2 * N + 1;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (m_valid) begin
        logic [N*10-1:0] ex, ey;
        for (int i = 0; i < N; i++) begin
          ex[10*i +: 10] = 10'(mbx[i]);
          ey[10*i +: 10] = 10'(mby[i]);
        end
        check("model_ball_x", 64'(ball_x), 64'(ex));
        check("model_ball_y", 64'(ball_y), 64'(ey));
        check("model_busy", 64'(busy), 64'(m_cnt != 0));
        check("model_frame_count", 64'(frame_count), 64'(m_fc));
        check("model_overrun", 64'(overrun), 64'(m_ov));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  // One vsync assertion; counts cycles with busy high over the following 10.
  task automatic run_frame(output int busy_cycles);
    busy_cycles = 0;
    vsync = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 0) vsync = 1'b1;
      if (busy) busy_cycles++;
    end
  endtask

  initial begin
    int bc;
    logic [N*10-1:0] sx, sy;
    logic [7:0] sfc;
    rst_n = 1'b0; vsync = 1'b1; pause = 1'b0; speed = 2'd0;
    tick(2);
    rst_n = 1'b1;
    check("reset_x", 64'(ball_x), 64'({10'd480, 10'd320, 10'd160}));
    check("reset_y", 64'(ball_y), 64'({10'd240, 10'd240, 10'd240}));
    check("reset_flags", 64'({busy, frame_count, overrun}), 64'(0));

    run_frame(bc);
    check("frame1_x", 64'(ball_x), 64'({10'd483, 10'd322, 10'd161}));
    check("frame1_y", 64'(ball_y), 64'({10'd244, 10'd237, 10'd242}));
    check("frame1_busy_cycles", 64'(bc), 64'(7));
    check("frame1_count", 64'(frame_count), 64'(1));

    do_reset();
    for (int f = 0; f < 42; f++) run_frame(bc);
    check("bounce_f42", 64'(ball_x[29:20]), 64'(606));
    run_frame(bc);
    check("bounce_f43", 64'(ball_x[29:20]), 64'(607));
    run_frame(bc);
    check("bounce_f44", 64'(ball_x[29:20]), 64'(604));

    do_reset();
    speed = 2'd3;
    run_frame(bc);
    speed = 2'd0;
    check("speed3_x0", 64'(ball_x[9:0]), 64'(164));
    check("speed3_y1", 64'(ball_y[19:10]), 64'(228));

    sx = ball_x; sy = ball_y; sfc = frame_count;
    pause = 1'b1;
    run_frame(bc);
    pause = 1'b0;
    check("pause_x", 64'(ball_x), 64'(sx));
    check("pause_y", 64'(ball_y), 64'(sy));
    check("pause_busy_cycles", 64'(bc), 64'(0));
    check("pause_count", 64'(frame_count), 64'(sfc + 8'd1));

    // Second frame start lands at E+3, in the middle of the update.
    do_reset();
    vsync = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) vsync = 1'b1;
      if (k == 2) vsync = 1'b0;
      if (k == 3) vsync = 1'b1;
      if (k == 6) check("overrun_pre_commit_x", 64'(ball_x), 64'({10'd480, 10'd320, 10'd160}));
    end
    check("overrun_flag", 64'(overrun), 64'(1));
    check("overrun_commit_x", 64'(ball_x), 64'({10'd483, 10'd322, 10'd161}));
    check("overrun_count", 64'(frame_count), 64'(2));

    do_reset();
    vsync = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 0) vsync = 1'b1;
      if (k == 3) rst_n = 1'b0;
    end
    check("midreset_x", 64'(ball_x), 64'({10'd480, 10'd320, 10'd160}));
    check("midreset_busy", 64'(busy), 64'(0));
    rst_n = 1'b1;
    tick(8);
    check("midreset_nocommit_x", 64'(ball_x), 64'({10'd480, 10'd320, 10'd160}));
    check("midreset_nocommit_y", 64'(ball_y), 64'({10'd240, 10'd240, 10'd240}));

    for (int it = 0; it < 500; it++) begin
      vsync = ~vsync;
      pause = ($urandom_range(0, 3) == 0);
      speed = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 60) == 0) rst_n = 1'b0;
      tick(int'($urandom_range(1, 12)));
      rst_n = 1'b1;
    end
    tick(12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/metaball_animator.md
# metaball_animator

Per-frame motion controller for the metaballs renderer. It holds the centre coordinates of every ball and updates them once per frame, at the start of vertical sync, while no pixels are being drawn. The update runs a sequential FSM that processes one axis of one ball per cycle, bounces each ball off the screen margins, and commits all new positions atomically. It sits between `hvsync_generator` (frame timing) and the metaballs pixel datapath (position consumer), with pause and speed taken from `ui_in`.

## Interface
- `NUM_BALLS`, 3: number of balls, 1..8.
- `SCREEN_WIDTH`, 640: horizontal resolution in pixels.
- `SCREEN_HEIGHT`, 480: vertical resolution in pixels.
- `MARGIN`, 32: minimum distance from a ball centre to any screen edge.
- `VSYNC_ACTIVE_LOW`, 1: vsync polarity; 1 means low = sync asserted.

Ports (name, direction, width, meaning):
- `clk` in 1: pixel clock; the only clock.
- `rst_n` in 1: reset; synchronous and active-low.
- `vsync` in 1: vsync from `hvsync_generator`.
- `pause` in 1: when high, position updates are skipped.
- `speed` in 2: step shift amount; 0..2, and 3 is treated as 2.
- `ball_x` out `NUM_BALLS*10`: committed X positions; ball i occupies bits [10i+9:10i].
- `ball_y` out `NUM_BALLS*10`: committed Y positions, same packing as `ball_x`.
- `busy` out 1: high while an update is in progress.
- `frame_count` out 8: count of detected frame starts; wraps 255→0.
- `overrun` out 1: sticky flag; set when a frame start arrives while `busy` is high.

## Operation
- **Reset values:**
  - X of ball i: `(i+1)*SCREEN_WIDTH/(NUM_BALLS+1)`, using integer division.
  - Y of every ball: `SCREEN_HEIGHT/2`.
  - X direction: positive for all balls.
  - Y direction: positive for even i, negative for odd i.
  - `busy`, `frame_count` and `overrun` are all 0.
  - Working registers equal the committed registers; the FSM is in IDLE.
- **Frame start:**
  - `vsync` is registered into `vs_q`.
  - `frame_start` is a one-cycle pulse, high when `vsync` is at its asserted level and `vs_q` is not.
- **FSM states:** IDLE, UPD_X, UPD_Y, COMMIT. The index register `idx` is 3 bits wide.
  - IDLE → UPD_X with `idx=0`, on `frame_start` when `pause=0`. `frame_count` increments on every `frame_start`, paused or not.
  - UPD_X → UPD_Y: updates X of ball `idx`.
  - UPD_Y → UPD_X with `idx+1`: updates Y of ball `idx`. When `idx == NUM_BALLS-1`, goes to COMMIT instead.
  - COMMIT → IDLE: copies all working registers to `ball_x`/`ball_y` in one cycle.
- **Axis update:**
  - Step size is `base << min(speed,2)`. X base is `idx+1`; Y base is `idx+2`.
  - Use an 11-bit unsigned intermediate; there is no wrap-around.
  - Bounds: `lo = MARGIN`; `hi = DIM-1-MARGIN`, where DIM is the screen width or height for that axis.
  - Positive direction: `n = p + step`. If `n > hi`, set `p = hi` and flip the direction; otherwise `p = n`.
  - Negative direction: if `p < lo + step`, set `p = lo` and flip the direction; otherwise `p = p - step`.
  - A ball sitting exactly on a bound moves normally; it is only clamped when it would cross.
- `speed` and `pause` are sampled only at `frame_start`. Speed is latched for the whole update.
- **Frame start during a non-IDLE state:**
  - The update in progress is not restarted.
  - `overrun` is set to 1 and stays set until reset.
  - `frame_count` still increments.
- **Reset mid-update:** all registers return to their reset values on the next clock edge. No partial commit is visible.

## Timing
- Let E be the clock edge at which `frame_start` is high.
- `busy` rises after E.
- Update cycles occupy E+1 through E+2·NUM_BALLS; COMMIT is the next cycle.
- New `ball_x`/`ball_y` are visible after edge E+2·NUM_BALLS+1 (edge E+7 for the default of 3 balls).
- `busy` falls on that same edge.
- `ball_x`/`ball_y` change only on the COMMIT edge and are stable at all other times.
- The total update takes far less than one vsync period, so any commit completes before active video.

## Test plan
- **Reset:** hold `rst_n=0` for 2 cycles, then release.
  - Require `ball_x` = {480,320,160} (ball2, ball1, ball0) and every `ball_y` = 240.
  - Require `busy=0`, `frame_count=0`, `overrun=0`.
- **One frame, speed 0:** one vsync falling edge.
  - After 7 cycles, require X = 161,322,483 and Y = 242,237,244.
  - Require `busy` high for exactly 7 cycles and `frame_count=1`.
- **Bounce:**
  - Run 42 frames at speed 0 and require ball2 X = 606.
  - Frame 43: require ball2 X = 607 (clamped, with hi = 607).
  - Frame 44: require ball2 X = 604.
- **Speed and pause:**
  - `speed=3`, one frame from reset: require ball0 X = 164 and ball1 Y = 228.
  - `pause=1`, one frame: require positions unchanged, `busy` never high, `frame_count` incremented.
- **Overrun:** issue a second vsync edge 3 cycles after the first.
  - Require `overrun=1`.
  - Require the commit to still occur at E+7 with single-frame values.
  - Require `frame_count=2`.
- **Reset mid-update:** assert `rst_n=0` at E+4.
  - Require reset positions on the following edge.
  - Require no commit and `busy=0`.
